mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WAIT_CYCLES, 3, data-memory access latency in cycles (legal range 1..15).
  DEPTH, 64, data-memory size in 32-bit words.
  BASE_ADDR, 1024, byte address mapped to word 0.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk, in, 1, the single clock, rising edge.
  rst, in, 1, asynchronous, active-high reset.
  WB_EN_IN, in, 1, register-writeback enable from the execute stage.
  MEM_R_EN_IN, in, 1, load request.
  MEM_W_EN_IN, in, 1, store request.
  ALU_Res_IN, in, 32, byte address, or the non-memory result.
  VAL_RM_IN, in, 32, store data.
  Dest_IN, in, 4, destination register.
  WB_EN, out, 1, writeback enable to the WB stage.
  MEM_R_EN, out, 1, selects Mem_Data in the WB stage.
  ALU_Res, out, 32, registered copy of ALU_Res_IN.
  Mem_Data, out, 32, load data.
  Dest, out, 4, registered destination.
  freeze, out, 1, stall request to all upstream pipeline registers.
  addr_err, out, 1, one-cycle pulse on an illegal access.

Function
REQ-003 The block SHALL contain a DEPTH x 32 data memory and a two-state FSM, IDLE and ACCESS, plus a 4-bit wait counter cnt.
REQ-004 A memory request ("req") SHALL be MEM_R_EN_IN | MEM_W_EN_IN.
REQ-005 freeze SHALL be combinational and equal (IDLE & req) | (ACCESS & cnt!=0).
REQ-006 In IDLE without req, every edge SHALL register WB_EN, ALU_Res and Dest from their inputs, with MEM_R_EN=0 and Mem_Data unchanged; latency is 1 cycle.
REQ-007 In IDLE with req, the edge SHALL move the FSM to ACCESS, load cnt=WAIT_CYCLES-1, and register a bubble: WB_EN=0, MEM_R_EN=0.
REQ-008 In ACCESS with cnt!=0, each edge SHALL decrement cnt and register a bubble; the inputs are held stable by the upstream stall.
REQ-009 In ACCESS with cnt==0, the edge SHALL complete the access and register WB_EN, MEM_R_EN, ALU_Res and Dest from the inputs; the FSM SHALL then return to IDLE.
REQ-010 freeze SHALL be high for exactly WAIT_CYCLES consecutive cycles per request, and the result SHALL appear WAIT_CYCLES+1 edges after the request is first presented.
REQ-011 Word index SHALL be (ALU_Res_IN - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic.
REQ-012 An access SHALL be illegal when any of the following holds: ALU_Res_IN < BASE_ADDR; ALU_Res_IN[1:0] != 0; word index >= DEPTH.
REQ-013 An illegal access SHALL leave the memory unchanged, force Mem_Data=0 for a load, and pulse addr_err high for the one cycle following completion.
REQ-014 A legal store SHALL write VAL_RM_IN to memory at the completion edge only.
REQ-015 A legal load SHALL register the memory word into Mem_Data at the completion edge.
REQ-016 MEM_R_EN_IN and MEM_W_EN_IN both high SHALL be treated as a store, with output MEM_R_EN=0.
REQ-017 Back-to-back requests SHALL each incur the full WAIT_CYCLES stall; the IDLE cycle after a completion SHALL re-assert freeze combinationally if req is present.

Reset
REQ-018 rst high SHALL immediately force, regardless of clk: FSM=IDLE, cnt=0, WB_EN=0, MEM_R_EN=0, ALU_Res=0, Mem_Data=0, Dest=0, addr_err=0; freeze then follows REQ-005 from IDLE.
REQ-019 Reset asserted during ACCESS SHALL abort the access with no memory write.
REQ-020 Memory contents SHALL NOT be reset.

Verification
REQ-021 Pass-through: non-memory op WB_EN_IN=1, ALU_Res_IN=0x55, Dest_IN=3 -> next edge WB_EN=1, ALU_Res=0x55, Dest=3, freeze never high.
REQ-022 Store then load: store 0xDEADBEEF to address 1032, then load from 1032 -> freeze high 3 cycles for each; after the load, Mem_Data=0xDEADBEEF, MEM_R_EN=1.
REQ-023 Bubbles: during each stall, WB_EN=0 and MEM_R_EN=0 at every freeze edge, and cnt steps 2,1,0.
REQ-024 Illegal addresses: load from 1020, 1026 or 1024+4*64 -> Mem_Data=0, addr_err pulses once, memory is unmodified.
REQ-025 Reset mid-store: rst asserted in the second ACCESS cycle of a store of 0x1234 to 1028 -> outputs 0 at once, and a later load of 1028 returns the prior contents.
REQ-026 Dual enables and WAIT_CYCLES=1: MEM_R_EN_IN=MEM_W_EN_IN=1 -> write performed, MEM_R_EN=0; with WAIT_CYCLES=1, freeze is high exactly 1 cycle.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: multi-cycle data-memory access with upstream freeze,
// bubble insertion during the wait, and address-range/alignment checking.
module mem_stage_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN_IN,
  input  logic        MEM_R_EN_IN,
  input  logic        MEM_W_EN_IN,
  input  logic [31:0] ALU_Res_IN,
  input  logic [31:0] VAL_RM_IN,
  input  logic [3:0]  Dest_IN,
  output logic        WB_EN,
  output logic        MEM_R_EN,
  output logic [31:0] ALU_Res,
  output logic [31:0] Mem_Data,
  output logic [3:0]  Dest,
  output logic        freeze,
  output logic        addr_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wb_en_q, wb_en_d;
  logic        mem_r_en_q, mem_r_en_d;
  logic [31:0] alu_res_q, alu_res_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  dest_q, dest_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] mem [DEPTH];
  logic        req, is_load, illegal, mem_we;
  logic [31:0] offs, idx, rd_word;

  assign req     = MEM_R_EN_IN | MEM_W_EN_IN;
  // Both enables high is a store; only a pure read returns load data.
  assign is_load = MEM_R_EN_IN & ~MEM_W_EN_IN;
  assign offs    = ALU_Res_IN - 32'(BASE_ADDR);
  assign idx     = offs >> 2;
  assign illegal = (ALU_Res_IN < 32'(BASE_ADDR)) | (ALU_Res_IN[1:0] != 2'b00) |
                   (idx >= 32'(DEPTH));
  assign rd_word = mem[idx[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wb_en_d    = 1'b0;
    mem_r_en_d = 1'b0;
    alu_res_d  = alu_res_q;
    mem_data_d = mem_data_q;
    dest_d     = dest_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    freeze     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          freeze  = 1'b1;
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES - 1);
        end else begin
          wb_en_d   = WB_EN_IN;
          alu_res_d = ALU_Res_IN;
          dest_d    = Dest_IN;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          freeze = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          state_d    = IDLE;
          wb_en_d    = WB_EN_IN;
          mem_r_en_d = is_load;
          alu_res_d  = ALU_Res_IN;
          dest_d     = Dest_IN;
          addr_err_d = illegal;
          mem_we     = MEM_W_EN_IN & ~illegal;
          if (is_load) mem_data_d = illegal ? 32'd0 : rd_word;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= 32'd0;
      mem_data_q <= 32'd0;
      dest_q     <= 4'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wb_en_q    <= wb_en_d;
      mem_r_en_q <= mem_r_en_d;
      alu_res_q  <= alu_res_d;
      mem_data_q <= mem_data_d;
      dest_q     <= dest_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage is never reset; reset forces IDLE so no write can complete.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx[AW-1:0]] <= VAL_RM_IN;
  end

  assign WB_EN    = wb_en_q;
  assign MEM_R_EN = mem_r_en_q;
  assign ALU_Res  = alu_res_q;
  assign Mem_Data = mem_data_q;
  assign Dest     = dest_q;
  assign addr_err = addr_err_q;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: default instance (3-cycle wait) plus a
// 1-cycle-wait instance for the dual-enable case.
module tb_mem_stage_ctrl;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_rm_in;
  logic [3:0]  dest_in;
  logic        WB_EN, MEM_R_EN, freeze, addr_err;
  logic [31:0] ALU_Res, Mem_Data;
  logic [3:0]  Dest;

  logic        wb_en_in1, mem_r_en_in1, mem_w_en_in1;
  logic [31:0] alu_res_in1, val_rm_in1;
  logic [3:0]  dest_in1;
  logic        WB_EN1, MEM_R_EN1, freeze1, addr_err1;
  logic [31:0] ALU_Res1, Mem_Data1;
  logic [3:0]  Dest1;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage_ctrl #(.WAIT_CYCLES(W), .DEPTH(64), .BASE_ADDR(1024)) u_dut (
    .clk(clk), .rst(rst), .WB_EN_IN(wb_en_in), .MEM_R_EN_IN(mem_r_en_in),
    .MEM_W_EN_IN(mem_w_en_in), .ALU_Res_IN(alu_res_in), .VAL_RM_IN(val_rm_in),
    .Dest_IN(dest_in), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALU_Res(ALU_Res),
    .Mem_Data(Mem_Data), .Dest(Dest), .freeze(freeze), .addr_err(addr_err));

  mem_stage_ctrl #(.WAIT_CYCLES(1), .DEPTH(64), .BASE_ADDR(1024)) u_dut1 (
    .clk(clk), .rst(rst), .WB_EN_IN(wb_en_in1), .MEM_R_EN_IN(mem_r_en_in1),
    .MEM_W_EN_IN(mem_w_en_in1), .ALU_Res_IN(alu_res_in1), .VAL_RM_IN(val_rm_in1),
    .Dest_IN(dest_in1), .WB_EN(WB_EN1), .MEM_R_EN(MEM_R_EN1), .ALU_Res(ALU_Res1),
    .Mem_Data(Mem_Data1), .Dest(Dest1), .freeze(freeze1), .addr_err(addr_err1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic wb, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d, input logic [3:0] dst);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = a; val_rm_in = d; dest_in = dst;
  endtask

  task automatic nop();
    set_in(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  // Call just after a rising edge. Returns 1 time unit after the completion
  // edge with the request still presented.
  task automatic mem_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] dst);
    int nfz;
    int k;
    nfz = 0;
    set_in(r & ~w, r, w, a, d, dst);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check("bubble_wb_en", 32'(WB_EN), 32'd0);
        check("bubble_mem_r_en", 32'(MEM_R_EN), 32'd0);
        check("wait_cnt", 32'(u_dut.cnt_q), 32'(W - k));
      end
      if (!freeze) break;
      nfz++;
      @(posedge clk);
    end
    check("freeze_len", 32'(nfz), 32'(W));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad [3];
    int nfz1;
    bad[0] = 32'd1020; bad[1] = 32'd1026; bad[2] = 32'd1280;
    nop();
    wb_en_in1 = 1'b0; mem_r_en_in1 = 1'b0; mem_w_en_in1 = 1'b0;
    alu_res_in1 = 32'd0; val_rm_in1 = 32'd0; dest_in1 = 4'd0;
    #1 rst = 1'b1;
    #11;
    check("rst_wb_en", 32'(WB_EN), 32'd0);
    check("rst_mem_r_en", 32'(MEM_R_EN), 32'd0);
    check("rst_alu_res", ALU_Res, 32'd0);
    check("rst_mem_data", Mem_Data, 32'd0);
    check("rst_dest", 32'(Dest), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Non-memory pass-through
    set_in(1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3);
    @(negedge clk);
    check("pt_freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1;
    check("pt_wb_en", 32'(WB_EN), 32'd1);
    check("pt_alu_res", ALU_Res, 32'h55);
    check("pt_dest", 32'(Dest), 32'd3);
    check("pt_mem_r_en", 32'(MEM_R_EN), 32'd0);
    check("pt_freeze2", 32'(freeze), 32'd0);

    // Store then back-to-back load
    mem_op(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd5);
    check("st_addr_err", 32'(addr_err), 32'd0);
    check("st_mem_r_en", 32'(MEM_R_EN), 32'd0);
    check("b2b_freeze", 32'(freeze), 32'd1);
    mem_op(1'b1, 1'b0, 32'd1032, 32'd0, 4'd6);
    check("ld_mem_data", Mem_Data, 32'hDEADBEEF);
    check("ld_mem_r_en", 32'(MEM_R_EN), 32'd1);
    check("ld_wb_en", 32'(WB_EN), 32'd1);
    check("ld_dest", 32'(Dest), 32'd6);
    check("ld_alu_res", ALU_Res, 32'd1032);
    check("ld_addr_err", 32'(addr_err), 32'd0);

    // Illegal loads: below base, misaligned, past the end
    for (int i = 0; i < 3; i++) begin
      mem_op(1'b1, 1'b0, bad[i], 32'd0, 4'd7);
      check("bad_ld_data", Mem_Data, 32'd0);
      check("bad_ld_err", 32'(addr_err), 32'd1);
      nop();
      @(posedge clk); #1;
      check("bad_ld_err_pulse", 32'(addr_err), 32'd0);
      mem_op(1'b1, 1'b0, 32'd1032, 32'd0, 4'd6);
      check("bad_ld_mem_kept", Mem_Data, 32'hDEADBEEF);
    end

    // Illegal store past the end must not alias onto word 0
    mem_op(1'b0, 1'b1, 32'd1024, 32'h11111111, 4'd1);
    mem_op(1'b0, 1'b1, 32'd1280, 32'hBAD0BAD0, 4'd1);
    check("bad_st_err", 32'(addr_err), 32'd1);
    mem_op(1'b1, 1'b0, 32'd1024, 32'd0, 4'd1);
    check("bad_st_mem_kept", Mem_Data, 32'h11111111);
    nop();
    @(posedge clk); #1;
    check("idle_mem_r_en", 32'(MEM_R_EN), 32'd0);

    // Reset in the second ACCESS cycle of a store
    mem_op(1'b0, 1'b1, 32'd1028, 32'hCAFE0001, 4'd2);
    mem_op(1'b1, 1'b0, 32'd1028, 32'd0, 4'd2);
    check("pre_rst_data", Mem_Data, 32'hCAFE0001);
    set_in(1'b0, 1'b0, 1'b1, 32'd1028, 32'h1234, 4'd9);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_wb_en", 32'(WB_EN), 32'd0);
    check("arst_mem_r_en", 32'(MEM_R_EN), 32'd0);
    check("arst_alu_res", ALU_Res, 32'd0);
    check("arst_mem_data", Mem_Data, 32'd0);
    check("arst_dest", 32'(Dest), 32'd0);
    check("arst_addr_err", 32'(addr_err), 32'd0);
    check("arst_cnt", 32'(u_dut.cnt_q), 32'd0);
    check("arst_freeze_idle_req", 32'(freeze), 32'd1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    nop();
    @(posedge clk); #1;
    mem_op(1'b1, 1'b0, 32'd1028, 32'd0, 4'd2);
    check("abort_no_write", Mem_Data, 32'hCAFE0001);
    nop();

    // WAIT_CYCLES=1 instance: dual enable is a store, then load it back
    wb_en_in1 = 1'b0; mem_r_en_in1 = 1'b1; mem_w_en_in1 = 1'b1;
    alu_res_in1 = 32'd1036; val_rm_in1 = 32'hA5A5A5A5; dest_in1 = 4'd4;
    nfz1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (freeze1) nfz1++;
      @(posedge clk);
    end
    #1;
    check("w1_dual_freeze_len", 32'(nfz1), 32'd1);
    check("w1_dual_mem_r_en", 32'(MEM_R_EN1), 32'd0);
    check("w1_dual_addr_err", 32'(addr_err1), 32'd0);
    wb_en_in1 = 1'b1; mem_w_en_in1 = 1'b0;
    nfz1 = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (freeze1) nfz1++;
      @(posedge clk);
    end
    #1;
    check("w1_ld_freeze_len", 32'(nfz1), 32'd1);
    check("w1_ld_mem_data", Mem_Data1, 32'hA5A5A5A5);
    check("w1_ld_mem_r_en", 32'(MEM_R_EN1), 32'd1);
    mem_r_en_in1 = 1'b0; wb_en_in1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
